// File: rtl/exp_arbiter.sv
// exp_arbiter: four-requester round-robin front end for a single shared
// Exponential unit. One transaction at a time flows IDLE -> START -> WAIT ->
// RESP -> IDLE. In IDLE the arbiter picks a requester and latches its
// operand. In START it pulses exp_start. In WAIT it waits for exp_done. In
// RESP it holds the result until the owning requester acknowledges it.
//
// Optional feature: define EXP_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles. An aborted transaction returns 18'h3FFFF with err = 1.
// Without the macro, WAIT waits indefinitely and err is tied low.

module exp_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active low
  input  logic [3:0]  req,
  input  logic [63:0] req_x,
  output logic [3:0]  gnt,
  output logic [3:0]  rsp_valid,
  output logic [17:0] rsp_data,
  input  logic [3:0]  rsp_ack,
  output logic        exp_start,
  output logic [15:0] exp_x,
  input  logic        exp_done,
  input  logic [1:0]  exp_int,
  input  logic [15:0] exp_frac,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The WAIT counter is 8 bits wide, so a larger TIMEOUT could never be reached.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("exp_arbiter: TIMEOUT must be in 1..255");
  end

  // Binary index of a one-hot owner vector.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [17:0] result_q, result_d;
  logic [15:0] exp_x_q, exp_x_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        exp_start_q, exp_start_d;
  logic [3:0]  rsp_valid_q, rsp_valid_d;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        err_q, err_d;
`endif

  // Round-robin selection: the first asserted request, scanning from ptr.
  logic        sel_found;
  logic [1:0]  sel_idx;
  logic [1:0]  scan_idx;

  // Scan the four requesters, starting at the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // Next-state logic for the transaction FSM and its registered outputs.
  always_comb begin
    // NOTE: every signal driven here gets its hold or idle value first, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    result_d    = result_q;
    exp_x_d     = exp_x_q;
    gnt_d       = 4'b0000;
    exp_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
`ifdef EXP_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 8'd1;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          owner_d     = 4'b0001 << sel_idx;
          gnt_d       = 4'b0001 << sel_idx;
          exp_x_d     = req_x[{sel_idx, 4'h0} +: 16];
          exp_start_d = 1'b1;
          state_d     = ST_START;
        end
      end

      ST_START: begin
`ifdef EXP_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
`ifdef EXP_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        // A done in the same cycle as the timeout takes priority.
        if (exp_done) begin
          result_d    = {exp_int, exp_frac};
          rsp_valid_d = owner_q;
`ifdef EXP_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_RESP;
        end
`ifdef EXP_ARB_TIMEOUT_EN
        else if (cnt_inc == TimeoutCnt) begin
          result_d    = 18'h3FFFF;
          rsp_valid_d = owner_q;
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end
`endif
      end

      ST_RESP: begin
        // Only the owner's acknowledge ends the transaction.
        if ((rsp_ack & owner_q) != 4'b0000) begin
          ptr_d       = onehot_idx(owner_q) + 2'd1;
          owner_d     = 4'b0000;
          rsp_valid_d = 4'b0000;
`ifdef EXP_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 4'b0000;
      ptr_q       <= 2'd0;
      result_q    <= 18'd0;
      exp_x_q     <= 16'd0;
      gnt_q       <= 4'b0000;
      exp_start_q <= 1'b0;
      rsp_valid_q <= 4'b0000;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values computed above regardless of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      result_q    <= result_d;
      exp_x_q     <= exp_x_d;
      gnt_q       <= gnt_d;
      exp_start_q <= exp_start_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign exp_start = exp_start_q;
  assign exp_x     = exp_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = (rsp_valid_q != 4'b0000) ? result_q : 18'd0;
  assign busy      = (state_q != ST_IDLE);
`ifdef EXP_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_exp_arbiter.sv
// Testbench for exp_arbiter. The bench plays both sides: the requesters and
// a stub Exponential unit. The stub answers with 1.0 + x/65536 after a
// programmable latency, so an operand of 0 returns {2'd1, 16'h0000}.
// Expected grants follow a round-robin model kept as a plain integer pointer.
// The timeout scenario runs when EXP_ARB_TIMEOUT_EN is defined.

module tb_exp_arbiter;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_x;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [17:0] rsp_data;
  logic [3:0]  rsp_ack;
  logic        exp_start;
  logic [15:0] exp_x;
  logic        exp_done;
  logic [1:0]  exp_int;
  logic [15:0] exp_frac;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int mptr     = 0;     // model round-robin pointer
  bit stub_en  = 1'b1;
  int exp_lat  = 0;

  exp_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ack   (rsp_ack),
    .exp_start (exp_start),
    .exp_x     (exp_x),
    .exp_done  (exp_done),
    .exp_int   (exp_int),
    .exp_frac  (exp_frac),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_stub(input logic [15:0] x);
    return 18'h10000 + {2'b00, x};
  endfunction

  // Round-robin reference: first requester at ptr, ptr+1, ... (mod 4).
  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return (i < 0) ? 4'b0000 : (v << i);
  endfunction

  // Stub Exponential unit: sees START, waits exp_lat WAIT cycles, pulses done.
  initial begin
    exp_done = 1'b0;
    exp_int  = 2'd0;
    exp_frac = 16'd0;
    forever begin
      @(negedge clk);
      if (stub_en && exp_start === 1'b1) begin
        @(posedge clk);
        repeat (exp_lat) @(posedge clk);
        #1;
        {exp_int, exp_frac} = exp_stub(exp_x);
        exp_done = 1'b1;
        @(posedge clk);
        #1 exp_done = 1'b0;
      end
    end
  end

  task automatic wait_gnt(output logic [3:0] g, output int cyc, output bit ok);
    g   = 4'b0000;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        g   = gnt;
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
    if (ok) req = req & ~g;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack(input logic [3:0] owner, input logic [3:0] req_after);
    rsp_ack = owner;
    req     = req_after;
    req_x   = {$urandom, $urandom};
    @(negedge clk);
    rsp_ack = 4'b0000;
  endtask

  task automatic serve_one(input logic [3:0] req_after, input int ack_delay,
                           output logic [3:0] g, output logic [3:0] rv,
                           output logic [17:0] d, output logic e, output bit ok);
    int cyc;
    bit ok2;
    rv = 4'b0000;
    d  = 18'd0;
    e  = 1'b0;
    wait_gnt(g, cyc, ok);
    if (!ok) return;
    wait_rsp(ok2);
    if (!ok2) begin
      ok = 1'b0;
      return;
    end
    rv = rsp_valid;
    d  = rsp_data;
    e  = err;
    repeat (ack_delay) @(negedge clk);
    do_ack(g, req_after);
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    req     = 4'b0000;
    req_x   = 64'd0;
    rsp_ack = 4'b0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt, rsp_valid, rsp_data, exp_start, exp_x, busy, err} !== 45'd0)
      $display("FAIL reset_outputs: got gnt=%b vld=%b data=%h st=%b x=%h busy=%b err=%b expected all 0",
               gnt, rsp_valid, rsp_data, exp_start, exp_x, busy, err);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000)
      $display("FAIL reset_idle: got busy=%b gnt=%b expected 0/0000", busy, gnt);
    else n_pass++;
    mptr = 0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    int cyc;
    bit ok;
    exp_lat = 2;
    req_x   = {$urandom, $urandom};
    req_x[15:0] = 16'h0000;
    req     = 4'b0001;
    wait_gnt(g, cyc, ok);
    n_checks++;
    if (!ok || g !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", g);
    else n_pass++;
    n_checks++;
    if (cyc !== 1) $display("FAIL single_latency: got %0d cycles expected 1", cyc);
    else n_pass++;
    n_checks++;
    if (exp_start !== 1'b1 || exp_x !== 16'h0000 || rsp_data !== 18'd0)
      $display("FAIL single_start: got start=%b x=%h data=%h expected 1/0000/0", exp_start, exp_x, rsp_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0000 || exp_start !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_pulse: got gnt=%b start=%b busy=%b expected 0000/0/1", gnt, exp_start, busy);
    else n_pass++;
    wait_rsp(ok);
    n_checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_data !== 18'h10000 || err !== 1'b0)
      $display("FAIL single_rsp: got vld=%b data=%h err=%b expected 0001/10000/0", rsp_valid, rsp_data, err);
    else n_pass++;
    do_ack(4'b0001, 4'b0000);
    n_checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 18'd0 || busy !== 1'b0)
      $display("FAIL single_clear: got vld=%b data=%h busy=%b expected 0/0/0", rsp_valid, rsp_data, busy);
    else n_pass++;
    mptr = 1;
  endtask

  task automatic test_contention();
    logic [3:0] g, rv;
    logic [17:0] d, xd;
    logic e;
    bit ok;
    int w;
    req   = 4'b1111;
    req_x = {$urandom, $urandom};
    for (int t = 0; t < 8; t++) begin
      exp_lat = $urandom_range(0, 3);
      w  = pick(mptr, 4'b1111);
      xd = exp_stub(req_x[16*w +: 16]);
      serve_one((t == 7) ? 4'b0000 : 4'b1111, 0, g, rv, d, e, ok);
      n_checks++;
      if (!ok || g !== oh(w) || rv !== oh(w) || d !== xd)
        $display("FAIL contention_%0d: got gnt=%b vld=%b data=%h expected %b/%b/%h", t, g, rv, d, oh(w), oh(w), xd);
      else n_pass++;
      mptr = (w + 1) % 4;
    end
  endtask

  task automatic test_pointer();
    logic [3:0] g, rv;
    logic [17:0] d;
    logic e;
    bit ok;
    exp_lat = 1;
    req = 4'b0100;
    serve_one(4'b0101, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== 4'b0100) $display("FAIL pointer_serve2: got %b expected 0100", g);
    else n_pass++;
    serve_one(4'b0100, 1, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== 4'b0001) $display("FAIL pointer_0_before_2: got %b expected 0001", g);
    else n_pass++;
    serve_one(4'b0000, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== 4'b0100) $display("FAIL pointer_then2: got %b expected 0100", g);
    else n_pass++;
    mptr = 3;
  endtask

  task automatic test_ack_holdoff();
    logic [3:0] g, rv, after;
    logic [17:0] d, xd;
    logic e;
    int cyc, w;
    bit ok;
    exp_lat = 0;
    req_x = {$urandom, $urandom};
    req   = 4'b0010;
    w  = pick(mptr, 4'b0010);
    xd = exp_stub(req_x[16*w +: 16]);
    wait_gnt(g, cyc, ok);
    n_checks++;
    if (!ok || g !== oh(w)) $display("FAIL holdoff_gnt: got %b expected %b", g, oh(w));
    else n_pass++;
    wait_rsp(ok);
    req = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      rsp_ack = ~oh(w) & 4'($urandom_range(0, 15));
      if (c == 4) begin
        {exp_int, exp_frac} = 18'($urandom);
        exp_done = 1'b1;
      end
      @(negedge clk);
      exp_done = 1'b0;
      n_checks++;
      if (rsp_valid !== oh(w) || gnt !== 4'b0000 || rsp_data !== xd || busy !== 1'b1)
        $display("FAIL holdoff_cycle_%0d: got vld=%b gnt=%b data=%h busy=%b expected %b/0000/%h/1",
                 c, rsp_valid, gnt, rsp_data, busy, oh(w), xd);
      else n_pass++;
    end
    rsp_ack = 4'b0000;
    do_ack(oh(w), 4'b1101);
    mptr = (w + 1) % 4;
    for (int t = 0; t < 3; t++) begin
      w     = pick(mptr, req);
      xd    = exp_stub(req_x[16*w +: 16]);
      after = req & ~oh(w);
      serve_one(after, $urandom_range(0, 2), g, rv, d, e, ok);
      n_checks++;
      if (!ok || g !== oh(w) || d !== xd)
        $display("FAIL holdoff_drain_%0d: got gnt=%b data=%h expected %b/%h", t, g, d, oh(w), xd);
      else n_pass++;
      mptr = (w + 1) % 4;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] g, rv;
    logic [17:0] d, xd;
    logic e;
    int cyc, w;
    bit ok;
    stub_en = 1'b0;
    req = 4'b1000;
    w = pick(mptr, 4'b1000);
    wait_gnt(g, cyc, ok);
    n_checks++;
    if (!ok || g !== oh(w)) $display("FAIL midwait_gnt: got %b expected %b", g, oh(w));
    else n_pass++;
    repeat (3) @(negedge clk);
    req = 4'b1001;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({gnt, rsp_valid, rsp_data, exp_start, exp_x, busy, err} !== 45'd0)
      $display("FAIL midwait_reset_outputs: got gnt=%b vld=%b data=%h st=%b x=%h busy=%b err=%b expected all 0",
               gnt, rsp_valid, rsp_data, exp_start, exp_x, busy, err);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    mptr    = 0;
    stub_en = 1'b1;
    exp_lat = 1;
    w  = pick(mptr, 4'b1001);
    xd = exp_stub(req_x[16*w +: 16]);
    serve_one(4'b1000, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== oh(w) || d !== xd)
      $display("FAIL midwait_ptr0: got gnt=%b data=%h expected %b/%h", g, d, oh(w), xd);
    else n_pass++;
    mptr = (w + 1) % 4;
    w = pick(mptr, 4'b1000);
    serve_one(4'b0000, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== oh(w)) $display("FAIL midwait_pending: got %b expected %b", g, oh(w));
    else n_pass++;
    mptr = (w + 1) % 4;
  endtask

  task automatic test_random();
    logic [3:0] g, rv, after;
    logic [17:0] d, xd;
    logic e;
    bit ok;
    int w;
    req   = 4'($urandom_range(1, 15));
    req_x = {$urandom, $urandom};
    for (int t = 0; t < 40; t++) begin
      exp_lat = $urandom_range(0, 4);
      w  = pick(mptr, req);
      xd = exp_stub(req_x[16*w +: 16]);
      after = (req & ~oh(w)) | 4'($urandom_range(0, 15));
      if (after == 4'b0000) after = oh($urandom_range(0, 3));
      if (t == 39) after = 4'b0000;
      serve_one(after, $urandom_range(0, 3), g, rv, d, e, ok);
      n_checks++;
      if (!ok || g !== oh(w) || rv !== oh(w) || d !== xd || e !== 1'b0)
        $display("FAIL random_%0d: got gnt=%b vld=%b data=%h err=%b expected %b/%b/%h/0",
                 t, g, rv, d, e, oh(w), oh(w), xd);
      else n_pass++;
      mptr = (w + 1) % 4;
    end
  endtask

`ifdef EXP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g, rv;
    logic [17:0] d, xd;
    logic e;
    int cyc, n;
    bit ok;
    stub_en = 1'b0;
    req = 4'b0010;
    wait_gnt(g, cyc, ok);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) break;
      n++;
    end
    n_checks++;
    if (n !== 8) $display("FAIL timeout_wait_cycles: got %0d expected 8", n);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== g || rsp_data !== 18'h3FFFF || err !== 1'b1)
      $display("FAIL timeout_rsp: got vld=%b data=%h err=%b expected %b/3ffff/1", rsp_valid, rsp_data, err, g);
    else n_pass++;
    do_ack(g, 4'b0000);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_clear: got err=%b busy=%b expected 0/0", err, busy);
    else n_pass++;
    mptr = 2;
    stub_en = 1'b1;
    exp_lat = 7;
    req = 4'b0100;
    xd  = exp_stub(req_x[47:32]);
    serve_one(4'b0000, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || d !== xd || e !== 1'b0)
      $display("FAIL timeout_done_wins: got data=%h err=%b expected %h/0", d, e, xd);
    else n_pass++;
    mptr = 3;
  endtask
`else
  task automatic test_long_wait();
    logic [3:0] g, rv;
    logic [17:0] d, xd;
    logic e;
    bit ok;
    exp_lat = 300;
    req = 4'b0100;
    xd  = exp_stub(req_x[47:32]);
    serve_one(4'b0000, 0, g, rv, d, e, ok);
    n_checks++;
    if (!ok || g !== oh(pick(mptr, 4'b0100)) || d !== xd || e !== 1'b0)
      $display("FAIL long_wait: got gnt=%b data=%h err=%b expected 0100/%h/0", g, d, e, xd);
    else n_pass++;
    mptr = 3;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_pointer();
    test_ack_holdoff();
    test_reset_mid_wait();
    test_random();
`ifdef EXP_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum WAIT-state cycles before abort (used only when EXP_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request from requester i; level, held until gnt[i] is seen.
REQ-005 req_x  input  64  packed operands; requester i uses bits [16i+15:16i].
REQ-006 gnt  output  4  one-hot, registered, one-cycle pulse when requester i's operand is latched.
REQ-007 rsp_valid  output  4  one-hot, result valid for owning requester.
REQ-008 rsp_data  output  18  shared result bus {intpart[1:0], fracpart[15:0]}.
REQ-009 rsp_ack  input  4  requester i accepts the result.
REQ-010 exp_start  output  1  start pulse to the shared Exponential unit.
REQ-011 exp_x  output  16  operand to the Exponential unit, stable from START until done.
REQ-012 exp_done, exp_int[1:0], exp_frac[15:0]  inputs  from the Exponential unit.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  high with rsp_valid when the result is a timeout abort.

Function
REQ-015 FSM states: IDLE, START, WAIT, RESP; registered one-hot owner[3:0]; 2-bit round-robin pointer ptr.
REQ-016 IDLE: if req != 0, select first asserted requester scanning ptr, ptr+1, ... modulo 4; latch its operand into exp_x, set owner, pulse gnt[owner]; next START. Else stay.
REQ-017 Latency req -> gnt: gnt asserts the cycle after the request is first seen in IDLE.
REQ-018 START: exp_start = 1 for exactly one cycle; next WAIT.
REQ-019 WAIT: on the first cycle exp_done = 1, capture {exp_int, exp_frac} into the result register; next RESP.
REQ-020 exp_done outside WAIT is ignored.
REQ-021 RESP: rsp_valid[owner] = 1, rsp_data = result register; on rsp_ack[owner] = 1, set ptr = owner+1 (mod 4), clear owner; next IDLE.
REQ-022 rsp_ack bits of non-owners are ignored; rsp_data is 0 whenever rsp_valid = 0.
REQ-023 Requests arriving or held during START/WAIT/RESP are not granted until IDLE; they are not lost as long as req is held.
REQ-024 req dropped after gnt has no effect on the in-flight operation.
REQ-025 All four requesters asserted continuously are served in order ptr, ptr+1, ..., with no requester starved for more than 3 transactions.
REQ-026 Minimum transaction: 4 cycles IDLE -> IDLE plus Exponential latency plus ack delay; back-to-back grant possible the cycle after return to IDLE.

Reset
REQ-027 rst low asynchronously forces state = IDLE, ptr = 0, owner = 0, result = 0, exp_x = 0.
REQ-028 While reset is active: gnt, rsp_valid, rsp_data, exp_start, busy, err = 0.
REQ-029 Reset mid-operation abandons the transaction; no response is issued; the Exponential unit is expected to be reset by the same rst domain.

Configuration
REQ-030 Macro EXP_ARB_TIMEOUT_EN defined: 8-bit counter clears on entry to WAIT and increments each WAIT cycle; at count = TIMEOUT without exp_done, go RESP with result = 18'h3FFFF and err = 1 until ack.
REQ-031 If exp_done and timeout occur in the same cycle, exp_done wins (normal result, err = 0).
REQ-032 Macro undefined: no counter, WAIT waits indefinitely, and err is tied to 0.

Verification
REQ-033 Single request: req = 4'b0001, x0 = 16'h0000 -> gnt = 4'b0001 one cycle, exp_start one pulse, rsp_data = Exponential result for 0 (intpart 1, frac 0), cleared after ack.
REQ-034 Contention: req = 4'b1111 held, ack immediately -> grant order 0, 1, 2, 3, 0, ...
REQ-035 Pointer: after serving 2, req = 4'b0101 -> requester 0 granted before 2.
REQ-036 Ack hold-off: withhold rsp_ack[owner] 10 cycles, pulse rsp_ack of other bits -> rsp_valid held, no new gnt; real ack -> IDLE.
REQ-037 Reset mid-WAIT: rst low -> all outputs 0 immediately; after release, pending req is granted with ptr = 0 priority.
REQ-038 With EXP_ARB_TIMEOUT_EN and TIMEOUT = 8, exp_done never asserted -> RESP after 8 WAIT cycles, rsp_data = 18'h3FFFF, err = 1.
